// File: rtl/spi_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_fifo_pkg                                                         |
// | Shared constants and width helper for the SPI master FIFO slice.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package spi_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH   = 32;
  localparam int unsigned DEFAULT_BUFFER_DEPTH = 8;

  // Ceiling log2; used to size pointers that index 0..value-1.
  function automatic int unsigned spi_clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_fifo_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_fifo_ptr                                                         |
// | Storage index counter wrapping from DEPTH-1 back to 0.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_fifo_ptr
  import spi_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = DEFAULT_BUFFER_DEPTH,
  parameter int unsigned PTR_WIDTH = spi_clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [PTR_WIDTH-1:0] ptr_o
);

  localparam logic [PTR_WIDTH-1:0] c_last = PTR_WIDTH'(DEPTH - 1);
  localparam logic [PTR_WIDTH-1:0] c_one  = PTR_WIDTH'(1);

  logic [PTR_WIDTH-1:0] r_ptr;

  // Flush wins over increment; the last slot wraps to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (clr_i) begin
      r_ptr <= '0;
    end else if (inc_i) begin
      r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + c_one;
    end
  end

  assign ptr_o = r_ptr;

endmodule
`default_nettype wire

// File: rtl/spi_master_fifo_wm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_master_fifo_wm                                                   |
// | Registered-output FIFO with level watermark, crossing pulse and      |
// | sticky overflow flag.                                                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_master_fifo_wm
  import spi_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned BUFFER_DEPTH = DEFAULT_BUFFER_DEPTH,
  parameter int unsigned CNT_WIDTH    = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i,
  input  logic [CNT_WIDTH-1:0]  thr_i,
  output logic [CNT_WIDTH-1:0]  elements_o,
  output logic                  wm_o,
  output logic                  wm_evt_o,
  output logic                  ovf_o
);

  localparam int unsigned          c_ptr_width = spi_clog2(BUFFER_DEPTH);
  localparam logic [CNT_WIDTH-1:0] c_depth_cnt = CNT_WIDTH'(BUFFER_DEPTH);
  localparam logic [CNT_WIDTH-1:0] c_one_cnt   = CNT_WIDTH'(1);

  logic [DATA_WIDTH-1:0]  r_mem [BUFFER_DEPTH];
  logic [c_ptr_width-1:0] w_rd_ptr;
  logic [c_ptr_width-1:0] w_wr_ptr;
  logic [CNT_WIDTH-1:0]   r_elements;
  logic                   r_ovf;
  logic                   r_wm_prev;
  logic                   r_wm_evt;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_wm;

  // Handshake flags come straight from the occupancy register, so a pop
  // in the same cycle never opens space for a write into a full FIFO.
  assign ready_o = (r_elements != c_depth_cnt);
  assign valid_o = (r_elements != '0);
  assign w_push  = valid_i & ready_o;
  assign w_pop   = valid_o & ready_i;
  assign w_wm    = (r_elements >= thr_i);

  spi_fifo_ptr #(
    .DEPTH     (BUFFER_DEPTH),
    .PTR_WIDTH (c_ptr_width)
  ) u_rd_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .inc_i  (w_pop),
    .ptr_o  (w_rd_ptr)
  );

  spi_fifo_ptr #(
    .DEPTH     (BUFFER_DEPTH),
    .PTR_WIDTH (c_ptr_width)
  ) u_wr_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .inc_i  (w_push),
    .ptr_o  (w_wr_ptr)
  );

  // Storage array; no reset, contents survive a flush.
  always_ff @(posedge clk_i) begin
    if (w_push && !clr_i) begin
      r_mem[w_wr_ptr] <= data_i;
    end
  end

  assign data_o = r_mem[w_rd_ptr];

  // Occupancy: unchanged on simultaneous push and pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_elements <= '0;
    end else if (clr_i) begin
      r_elements <= '0;
    end else if (w_push && !w_pop) begin
      r_elements <= r_elements + c_one_cnt;
    end else if (w_pop && !w_push) begin
      r_elements <= r_elements - c_one_cnt;
    end
  end

  // Sticky overflow and watermark-crossing pulse. A zero threshold keeps
  // the level permanently high, so there is nothing to cross.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovf     <= 1'b0;
      r_wm_evt  <= 1'b0;
      r_wm_prev <= 1'b0;
    end else if (clr_i) begin
      r_ovf     <= 1'b0;
      r_wm_evt  <= 1'b0;
      r_wm_prev <= w_wm;
    end else begin
      r_ovf     <= r_ovf | (valid_i & ~ready_o);
      r_wm_evt  <= w_wm & ~r_wm_prev & (thr_i != '0);
      r_wm_prev <= w_wm;
    end
  end

  assign elements_o = r_elements;
  assign wm_o       = w_wm;
  assign wm_evt_o   = r_wm_evt;
  assign ovf_o      = r_ovf;

endmodule
`default_nettype wire

// File: doc/spi_master_fifo_wm.md
SPI_MASTER_FIFO_WM -- requirements
Module: spi_master_fifo_wm

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 The block SHALL have parameter BUFFER_DEPTH, default 8, number of entries, any integer >= 2 (non-power-of-two legal).
REQ-003 The block SHALL have parameter CNT_WIDTH, default $clog2(BUFFER_DEPTH+1), width of every level/threshold field.
REQ-004 The block SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port clr_i  input  1  synchronous flush of contents, pointers and sticky flags.
REQ-007 The block SHALL have port valid_i  input  1  write request.
REQ-008 The block SHALL have port data_i  input  DATA_WIDTH  write data.
REQ-009 The block SHALL have port ready_o  output  1  space available.
REQ-010 The block SHALL have port valid_o  output  1  data available.
REQ-011 The block SHALL have port data_o  output  DATA_WIDTH  head entry.
REQ-012 The block SHALL have port ready_i  input  1  read acknowledge.
REQ-013 The block SHALL have port thr_i  input  CNT_WIDTH  watermark level.
REQ-014 The block SHALL have port elements_o  output  CNT_WIDTH  current occupancy.
REQ-015 The block SHALL have port wm_o  output  1  level flag, elements_o >= thr_i.
REQ-016 The block SHALL have port wm_evt_o  output  1  single-cycle pulse on watermark crossing.
REQ-017 The block SHALL have port ovf_o  output  1  sticky overflow flag.

Function
REQ-018 Push SHALL occur when valid_i && ready_o; pop SHALL occur when valid_o && ready_i.
REQ-019 ready_o SHALL equal (elements != BUFFER_DEPTH) and valid_o SHALL equal (elements != 0), both decoded from registers only.
REQ-020 Data pushed in cycle N SHALL appear on data_o with valid_o=1 in cycle N+1 (no fall-through); data_o SHALL hold the entry at the read pointer.
REQ-021 Ordering SHALL be strict FIFO; data_o SHALL be stable while valid_o=1 and ready_i=0.
REQ-022 Write and read pointers SHALL wrap from BUFFER_DEPTH-1 to 0.
REQ-023 Simultaneous push and pop SHALL leave elements unchanged and advance both pointers.
REQ-024 When full, a write SHALL be rejected even if a pop occurs in the same cycle.
REQ-025 valid_i=1 while full SHALL set ovf_o from the next cycle; ovf_o SHALL hold until clr_i or reset, and the data SHALL be dropped.
REQ-026 wm_evt_o SHALL pulse for one cycle in the cycle after elements goes from < thr_i to >= thr_i; thr_i changes also count as crossings.
REQ-027 thr_i=0 SHALL hold wm_o at 1 and generate no wm_evt_o after reset; thr_i > BUFFER_DEPTH SHALL hold wm_o at 0.
REQ-028 clr_i SHALL take priority over push and pop in the same cycle: elements, pointers and ovf_o go to 0, wm_evt_o is suppressed, and storage contents are not cleared.

Reset
REQ-029 On rst_ni=0, pointers, elements_o, ovf_o, wm_evt_o and the previous-watermark register SHALL go to 0 asynchronously; valid_o=0 and ready_o=1.
REQ-030 Storage SHALL not require reset; data_o SHALL be don't-care while valid_o=0.
REQ-031 Reset asserted mid-transfer SHALL discard all contents, with no pop or push completing in that cycle.

Structure
REQ-032 Package spi_fifo_pkg SHALL hold the shared log2/clog2 helper function and the default DATA_WIDTH/BUFFER_DEPTH constants.
REQ-033 Sub-module spi_fifo_ptr, a wrap-at-DEPTH counter with inc/clr inputs, SHALL be instantiated twice, once for the read pointer and once for the write pointer.

Verification
REQ-034 Verification SHALL cover: after reset, push 0xA0..0xA7 into DEPTH=8 -> ready_o=0 after the 8th, elements_o=8, pops return 0xA0..0xA7 in order.
REQ-035 Verification SHALL cover: full FIFO, valid_i=1 with data 0xDEAD and ready_i=1 -> one pop, 0xDEAD not stored, ovf_o=1 from the next cycle until clr_i.
REQ-036 Verification SHALL cover: thr_i=3, push 3 -> wm_evt_o pulses once with elements_o=3; pop 1 and push 1 -> exactly one further pulse.
REQ-037 Verification SHALL cover: DEPTH=5, 20 cycles of continuous push+pop -> elements_o constant, pointers wrap, data in order.
REQ-038 Verification SHALL cover: clr_i asserted together with push and pop at elements=4 -> next cycle elements_o=0, valid_o=0, ovf_o=0.
REQ-039 Verification SHALL cover: rst_ni pulsed low mid-stream with 3 entries held -> valid_o=0 and elements_o=0 immediately, with no clock edge needed.
